// File: rtl/div_issue_queue.sv
// Issue queue for the 8-bit serial divider: FIFO of tagged operand pairs, one op in flight,
// result returned over valid/ready. Optional macro DIV_ZERO_BYPASS_EN answers b=0 locally.
module div_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             I_clk,
    input  logic             I_rst_p,
    input  logic             I_req_valid,
    output logic             O_req_ready,
    input  logic [7:0]       I_req_a,
    input  logic [7:0]       I_req_b,
    input  logic [TAG_W-1:0] I_req_tag,
    output logic             O_div_valid,
    output logic [7:0]       O_div_a,
    output logic [7:0]       O_div_b,
    input  logic             I_div_valid,
    input  logic [7:0]       I_div_shang,
    input  logic [7:0]       I_div_yushu,
    output logic             O_res_valid,
    input  logic             I_res_ready,
    output logic [7:0]       O_res_quot,
    output logic [7:0]       O_res_rem,
    output logic [TAG_W-1:0] O_res_tag,
    output logic             O_res_dz,
    output logic             O_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = TAG_W + 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    // Handshakes: a transfer happens on a rising edge where both valid and ready are high;
    // valid never waits on ready, and payload stays stable while valid is held.
    state_t            r_state;
    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              r_div_valid;
    logic [7:0]        r_div_a;
    logic [7:0]        r_div_b;
    logic [TAG_W-1:0]  r_iss_tag;
    logic              r_res_valid;
    logic [7:0]        r_res_quot;
    logic [7:0]        r_res_rem;
    logic [TAG_W-1:0]  r_res_tag;
`ifdef DIV_ZERO_BYPASS_EN
    logic              r_res_dz;
`endif

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic [EW-1:0]     w_head;
    logic [7:0]        w_head_a;
    logic [7:0]        w_head_b;
    logic [TAG_W-1:0]  w_head_tag;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push     = I_req_valid && !w_full;
    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign w_head_a   = w_head[7:0];
    assign w_head_b   = w_head[15:8];
    assign w_head_tag = w_head[EW-1:16];

    always_ff @(posedge I_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {I_req_tag, I_req_b, I_req_a};
        end
    end

    always_ff @(posedge I_clk or posedge I_rst_p) begin
        if (I_rst_p) begin
            r_wptr <= '0;
        end else if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    // The read pointer advances only on an IDLE pop, so it lives with the FSM.
    always_ff @(posedge I_clk or posedge I_rst_p) begin
        if (I_rst_p) begin
            r_state     <= IDLE;
            r_rptr      <= '0;
            r_div_valid <= 1'b0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_iss_tag   <= '0;
            r_res_valid <= 1'b0;
            r_res_quot  <= '0;
            r_res_rem   <= '0;
            r_res_tag   <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            r_res_dz    <= 1'b0;
`endif
        end else begin
            r_div_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_rptr    <= r_rptr + 1'b1;
                        r_iss_tag <= w_head_tag;
`ifdef DIV_ZERO_BYPASS_EN
                        if (w_head_b == 8'd0) begin
                            r_res_quot  <= 8'hFF;
                            r_res_rem   <= w_head_a;
                            r_res_tag   <= w_head_tag;
                            r_res_dz    <= 1'b1;
                            r_res_valid <= 1'b1;
                            r_state     <= HOLD;
                        end else
`endif
                        begin
                            r_div_a     <= w_head_a;
                            r_div_b     <= w_head_b;
                            r_div_valid <= 1'b1;
                            r_state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (I_div_valid) begin
                        r_res_quot  <= I_div_shang;
                        r_res_rem   <= I_div_yushu;
                        r_res_tag   <= r_iss_tag;
`ifdef DIV_ZERO_BYPASS_EN
                        r_res_dz    <= 1'b0;
`endif
                        r_res_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (I_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign O_req_ready = !w_full;
    assign O_div_valid = r_div_valid;
    assign O_div_a     = r_div_a;
    assign O_div_b     = r_div_b;
    assign O_res_valid = r_res_valid;
    assign O_res_quot  = r_res_quot;
    assign O_res_rem   = r_res_rem;
    assign O_res_tag   = r_res_tag;
`ifdef DIV_ZERO_BYPASS_EN
    assign O_res_dz    = r_res_dz;
`else
    assign O_res_dz    = 1'b0;
`endif
    assign O_busy      = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue with a behavioural 19-cycle divider model.
// Build with +define+DIV_ZERO_BYPASS_EN to exercise the zero-divisor bypass.
module tb_div_issue_queue;
    logic       I_clk = 1'b0;
    logic       I_rst_p;
    logic       I_req_valid;
    logic       O_req_ready;
    logic [7:0] I_req_a;
    logic [7:0] I_req_b;
    logic [3:0] I_req_tag;
    logic       O_div_valid;
    logic [7:0] O_div_a;
    logic [7:0] O_div_b;
    logic       I_div_valid;
    logic [7:0] I_div_shang;
    logic [7:0] I_div_yushu;
    logic       O_res_valid;
    logic       I_res_ready;
    logic [7:0] O_res_quot;
    logic [7:0] O_res_rem;
    logic [3:0] O_res_tag;
    logic       O_res_dz;
    logic       O_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_iss = -1000;

    div_issue_queue #(.DEPTH(4), .TAG_W(4)) dut (
        .I_clk(I_clk), .I_rst_p(I_rst_p),
        .I_req_valid(I_req_valid), .O_req_ready(O_req_ready),
        .I_req_a(I_req_a), .I_req_b(I_req_b), .I_req_tag(I_req_tag),
        .O_div_valid(O_div_valid), .O_div_a(O_div_a), .O_div_b(O_div_b),
        .I_div_valid(I_div_valid), .I_div_shang(I_div_shang), .I_div_yushu(I_div_yushu),
        .O_res_valid(O_res_valid), .I_res_ready(I_res_ready),
        .O_res_quot(O_res_quot), .O_res_rem(O_res_rem), .O_res_tag(O_res_tag),
        .O_res_dz(O_res_dz), .O_busy(O_busy)
    );

    // clock / cycle counter
    always #5 I_clk = ~I_clk;
    always @(posedge I_clk) cyc++;

    // divider model: result pulse 19 cycles after the start cycle
    int         m_cnt = 0;
    logic [7:0] m_a = 8'd0;
    logic [7:0] m_b = 8'd0;
    logic       inj_v = 1'b0;
    logic [7:0] inj_q = 8'd0;
    logic [7:0] inj_r = 8'd0;
    logic       m_pulse;

    always @(posedge I_clk) begin
        if (O_div_valid) begin
            m_cnt <= 19;
            m_a   <= O_div_a;
            m_b   <= O_div_b;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign m_pulse     = (m_cnt == 1);
    assign I_div_valid = m_pulse | inj_v;
    assign I_div_shang = inj_v ? inj_q : ((m_b == 8'd0) ? 8'hFF : m_a / m_b);
    assign I_div_yushu = inj_v ? inj_r : ((m_b == 8'd0) ? m_a : m_a % m_b);

    // issue spacing monitor
    always @(negedge I_clk) begin
        if (!I_rst_p && O_div_valid === 1'b1) begin
            n_cmp++;
            if (cyc - last_iss < 21) begin
                n_err++;
                $display("FAIL issue_gap: got %0d cycles want >=21", cyc - last_iss);
            end
            last_iss = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                        output int p);
        I_req_valid = 1'b1;
        I_req_a     = a;
        I_req_b     = b;
        I_req_tag   = t;
        @(negedge I_clk);
        I_req_valid = 1'b0;
        p = cyc;
    endtask

    task automatic wait_div(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            if (O_div_valid === 1'b1) begin
                at = cyc;
                break;
            end
            @(negedge I_clk);
        end
    endtask

    task automatic wait_res(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            if (O_res_valid === 1'b1) begin
                at = cyc;
                break;
            end
            @(negedge I_clk);
        end
    endtask

    task automatic test_reset();
        logic [40:0] got;
        logic [40:0] exp;
        I_rst_p = 1'b1; I_req_valid = 1'b0; I_req_a = '0; I_req_b = '0; I_req_tag = '0;
        I_res_ready = 1'b0;
        repeat (3) @(negedge I_clk);
        exp = {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0};
        got = {O_req_ready, O_div_valid, O_div_a, O_div_b, O_res_valid,
               O_res_quot, O_res_rem, O_res_tag, O_res_dz, O_busy};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_in: got %h want %h", got, exp); end
        I_rst_p = 1'b0;
        @(negedge I_clk);
        got = {O_req_ready, O_div_valid, O_div_a, O_div_b, O_res_valid,
               O_res_quot, O_res_rem, O_res_tag, O_res_dz, O_busy};
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_out: got %h want %h", got, exp); end
    endtask

    task automatic test_single();
        int p, at;
        I_res_ready = 1'b0;
        push(8'd100, 8'd7, 4'd3, p);
        n_cmp++;
        if (O_div_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %b want 0", O_div_valid); end
        wait_div(at);
        n_cmp++;
        if (at != p + 1) begin n_err++; $display("FAIL single_issue_time: got %0d want %0d", at, p + 1); end
        n_cmp++;
        if ({O_div_a, O_div_b} !== {8'd100, 8'd7}) begin
            n_err++; $display("FAIL single_operands: got %0d/%0d want 100/7", O_div_a, O_div_b);
        end
        @(negedge I_clk);
        n_cmp++;
        if (O_div_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse_len: got %b want 0", O_div_valid); end
        wait_res(at);
        n_cmp++;
        if (at != p + 21) begin n_err++; $display("FAIL single_res_time: got %0d want %0d", at, p + 21); end
        n_cmp++;
        if ({O_res_quot, O_res_rem, O_res_tag, O_res_dz} !== {8'd14, 8'd2, 4'd3, 1'b0}) begin
            n_err++; $display("FAIL single_result: got q=%0d r=%0d t=%0d dz=%b want 14 2 3 0",
                              O_res_quot, O_res_rem, O_res_tag, O_res_dz);
        end
        I_res_ready = 1'b1;
        @(negedge I_clk);
        n_cmp++;
        if ({O_res_valid, O_busy} !== 2'b00) begin
            n_err++; $display("FAIL single_accept: got valid/busy=%b%b want 00", O_res_valid, O_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [5] = '{8'd20, 8'd200, 8'd7, 8'd0, 8'd99};
        logic [7:0]  vb [5] = '{8'd3, 8'd9, 8'd7, 8'd5, 8'd10};
        logic [7:0]  eq [5] = '{8'd6, 8'd22, 8'd1, 8'd0, 8'd9};
        logic [7:0]  er [5] = '{8'd2, 8'd2, 8'd0, 8'd0, 8'd9};
        logic [19:0] exp_q [$];
        logic [19:0] e;
        int p;
        I_res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (O_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got 0 want 1", i); end
            exp_q.push_back({4'(i + 1), eq[i], er[i]});
            push(va[i], vb[i], 4'(i + 1), p);
        end
        n_cmp++;
        if (O_req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b want 0", O_req_ready); end
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            if (O_res_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({O_res_tag, O_res_quot, O_res_rem} !== e) begin
                    n_err++; $display("FAIL b2b_result: got %h want %h", {O_res_tag, O_res_quot, O_res_rem}, e);
                end
            end
            @(negedge I_clk);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_hold();
        int p, at;
        logic [21:0] got;
        logic [21:0] exp;
        I_res_ready = 1'b0;
        push(8'd255, 8'd16, 4'd5, p);
        wait_res(at);
        n_cmp++;
        if (at != p + 21) begin n_err++; $display("FAIL hold_res_time: got %0d want %0d", at, p + 21); end
        push(8'd50, 8'd5, 4'd6, p);
        exp = {1'b1, 1'b0, 8'd15, 8'd15, 4'd5};
        for (int i = 0; i < 50; i++) begin
            got = {O_res_valid, O_div_valid, O_res_quot, O_res_rem, O_res_tag};
            n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL hold_stable_%0d: got %h want %h", i, got, exp); end
            @(negedge I_clk);
        end
        I_res_ready = 1'b1;
        @(negedge I_clk);
        n_cmp++;
        if ({O_res_valid, O_div_valid} !== 2'b00) begin
            n_err++; $display("FAIL hold_idle: got %b%b want 00", O_res_valid, O_div_valid);
        end
        @(negedge I_clk);
        n_cmp++;
        if ({O_div_valid, O_div_a, O_div_b} !== {1'b1, 8'd50, 8'd5}) begin
            n_err++; $display("FAIL hold_next_issue: got %b %0d %0d want 1 50 5", O_div_valid, O_div_a, O_div_b);
        end
        wait_res(at);
        n_cmp++;
        if ({O_res_quot, O_res_rem, O_res_tag} !== {8'd10, 8'd0, 4'd6}) begin
            n_err++; $display("FAIL hold_second: got %0d %0d %0d want 10 0 6", O_res_quot, O_res_rem, O_res_tag);
        end
        @(negedge I_clk);
    endtask

    task automatic test_spurious();
        int p, at;
        inj_q = 8'h11; inj_r = 8'h22; inj_v = 1'b1;
        @(negedge I_clk);
        inj_v = 1'b0;
        @(negedge I_clk);
        n_cmp++;
        if ({O_res_valid, O_res_quot, O_res_rem, O_res_tag, O_busy} !== {1'b0, 8'd10, 8'd0, 4'd6, 1'b0}) begin
            n_err++; $display("FAIL spur_idle: got v=%b q=%0d r=%0d t=%0d busy=%b want 0 10 0 6 0",
                              O_res_valid, O_res_quot, O_res_rem, O_res_tag, O_busy);
        end
        I_res_ready = 1'b0;
        push(8'd9, 8'd2, 4'd1, p);
        wait_res(at);
        inj_q = 8'h33; inj_r = 8'h44; inj_v = 1'b1;
        @(negedge I_clk);
        inj_v = 1'b0;
        @(negedge I_clk);
        n_cmp++;
        if ({O_res_valid, O_res_quot, O_res_rem, O_res_tag} !== {1'b1, 8'd4, 8'd1, 4'd1}) begin
            n_err++; $display("FAIL spur_hold: got v=%b q=%0d r=%0d t=%0d want 1 4 1 1",
                              O_res_valid, O_res_quot, O_res_rem, O_res_tag);
        end
        I_res_ready = 1'b1;
        repeat (2) @(negedge I_clk);
    endtask

    task automatic test_zero();
        int p, at;
        I_res_ready = 1'b0;
        push(8'd42, 8'd0, 4'd9, p);
`ifdef DIV_ZERO_BYPASS_EN
        n_cmp++;
        if ({O_res_valid, O_div_valid} !== 2'b00) begin
            n_err++; $display("FAIL zero_early: got %b%b want 00", O_res_valid, O_div_valid);
        end
        @(negedge I_clk);
        n_cmp++;
        if ({O_res_valid, O_div_valid, O_res_quot, O_res_rem, O_res_tag, O_res_dz}
            !== {1'b1, 1'b0, 8'hFF, 8'd42, 4'd9, 1'b1}) begin
            n_err++; $display("FAIL zero_bypass: got v=%b dv=%b q=%h r=%0d t=%0d dz=%b want 1 0 ff 42 9 1",
                              O_res_valid, O_div_valid, O_res_quot, O_res_rem, O_res_tag, O_res_dz);
        end
        I_res_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge I_clk);
            n_cmp++;
            if (O_div_valid !== 1'b0) begin n_err++; $display("FAIL zero_no_issue_%0d: got 1 want 0", i); end
        end
`else
        wait_div(at);
        n_cmp++;
        if (at != p + 1 || O_div_b !== 8'd0) begin
            n_err++; $display("FAIL zero_issue: got t=%0d b=%0d want t=%0d b=0", at, O_div_b, p + 1);
        end
        wait_res(at);
        n_cmp++;
        if ({O_res_quot, O_res_rem, O_res_tag, O_res_dz} !== {8'hFF, 8'd42, 4'd9, 1'b0}) begin
            n_err++; $display("FAIL zero_raw: got q=%h r=%0d t=%0d dz=%b want ff 42 9 0",
                              O_res_quot, O_res_rem, O_res_tag, O_res_dz);
        end
        I_res_ready = 1'b1;
        repeat (2) @(negedge I_clk);
`endif
    endtask

    task automatic test_reset_mid();
        int p;
        logic [40:0] got;
        logic [40:0] exp;
        I_res_ready = 1'b1;
        push(8'd60, 8'd7, 4'd2, p);
        push(8'd61, 8'd7, 4'd3, p);
        push(8'd62, 8'd7, 4'd4, p);
        push(8'd63, 8'd7, 4'd5, p);
        repeat (5) @(negedge I_clk);
        n_cmp++;
        if ({O_busy, O_res_valid} !== 2'b10) begin
            n_err++; $display("FAIL mid_pre: got busy/valid=%b%b want 10", O_busy, O_res_valid);
        end
        I_rst_p = 1'b1;
        repeat (2) @(negedge I_clk);
        I_rst_p = 1'b0;
        exp = {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0};
        for (int i = 0; i < 30; i++) begin
            @(negedge I_clk);
            got = {O_req_ready, O_div_valid, O_div_a, O_div_b, O_res_valid,
                   O_res_quot, O_res_rem, O_res_tag, O_res_dz, O_busy};
            n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL mid_reset_%0d: got %h want %h", i, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_spurious();
        test_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
